sin_series_ctrl: RTL and testbench
==================================

SIN_SERIES_CTRL -- requirements
Module: sin_series_ctrl

Interface
REQ-001 SHALL have parameter NTERMS, default 5, number of series correction terms (legal 1..5).
REQ-002 SHALL have parameter FRAC, default 8, fractional bits of every Q8.8 signed data value.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have port start  input  1  request to evaluate sin(x); sampled only in IDLE.
REQ-006 SHALL have port x  input  16  operand, signed Q8.8, captured on the accepting edge.
REQ-007 SHALL have port div  input  16  coefficient from the external coefficient table, unsigned Q8.8.
REQ-008 SHALL have port sel  output  3  coefficient-table index k (0..NTERMS-1); codes 5..7 never driven.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port result  output  16  signed Q8.8 sin(x) approximation, held until next done.

Function
REQ-012 SHALL implement FSM states IDLE, SQR, MUL, SCL, ACC, DONE; all outputs registered.
REQ-013 IDLE with start=1 at an edge SHALL latch x, set term<=x, acc<=x, k<=0, go to SQR; start=0 stays IDLE.
REQ-014 SQR SHALL compute x2 <= qmul(x, x) and go to MUL.
REQ-015 MUL SHALL compute term <= qmul(term, x2) and go to SCL.
REQ-016 SCL SHALL drive sel=k and compute term <= sat(-qmul(term, div)), go to ACC.
REQ-017 ACC SHALL compute acc <= sat(acc + term); if k==NTERMS-1 load result <= new acc and go to DONE, else k<=k+1 and go to MUL.
REQ-018 DONE SHALL assert done for exactly one cycle and return to IDLE at the next edge.
REQ-019 qmul(a,b) SHALL form the full 32-bit signed product, arithmetic-shift right by FRAC (floor), and saturate to 16-bit signed (0x7FFF / 0x8000); div treated as non-negative.
REQ-020 sat() SHALL saturate 17-bit sums/negations to 16-bit signed; -(0x8000) yields 0x7FFF.
REQ-021 Latency: done SHALL be high in the cycle after the (1+3*NTERMS)th edge following the accepting edge (edge 16 for NTERMS=5); busy high from accepting edge until return to IDLE.
REQ-022 start while busy (including DONE) SHALL be ignored, with no queuing; x changes while busy SHALL not affect the result.
REQ-023 sel SHALL hold its last value outside SCL; it SHALL equal k for the whole SCL cycle.
REQ-024 result SHALL change only on the edge entering DONE or on reset.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, k=0, sel=0, busy=0, done=0, result=0, term/acc/x2=0, from any state including mid-evaluation.
REQ-026 start coincident with rst SHALL be ignored; first acceptable start is on the edge after rst deasserts.

Structure
REQ-027 Package sin_series_pkg SHALL hold the state enum, Q8.8 width/FRAC constants, MAX_TERMS=5, and the saturation helper function.
REQ-028 One sub-module q88_mul (combinational signed Q8.8 saturating multiply, REQ-019) SHALL be instantiated once and shared across SQR/MUL/SCL.
REQ-029 The coefficient table SHALL stay external, connected via sel/div.

Verification
REQ-030 x=0x0100 (1.0), start one cycle -> done 16 edges after accept, result=0x00D8, sel sequence 0..4 in SCL cycles.
REQ-031 x=0xFF00 (-1.0) -> result=0xFF2A (floor asymmetry intended).
REQ-032 x=0x0000 -> result=0x0000, same 16-edge latency.
REQ-033 x=0x7FFF -> all intermediates saturate, result within 16-bit signed, no wrap (check against bit-exact model).
REQ-034 start pulsed again at edges 3 and 16 after accept -> ignored, exactly one done, result unchanged until next accepted start.
REQ-035 rst asserted in MUL of k=2 -> next cycle busy=0, done=0, result=0, sel=0; new start then completes normally.

Source files
------------

// File: rtl/sin_series_pkg.sv
// Shared types, Q8.8 constants and the saturation helper for the sin series controller.
package sin_series_pkg;

  localparam int Q_W       = 16;
  localparam int Q_FRAC    = 8;
  localparam int MAX_TERMS = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SQR  = 3'd1,
    ST_MUL  = 3'd2,
    ST_SCL  = 3'd3,
    ST_ACC  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // Clamp a 17-bit signed sum or negation into the 16-bit signed range.
  function automatic logic signed [Q_W-1:0] sat17(input logic signed [Q_W:0] v);
    if (v[Q_W] != v[Q_W-1]) begin
      return v[Q_W] ? 16'sh8000 : 16'sh7FFF;
    end
    return $signed(v[Q_W-1:0]);
  endfunction

endpackage

// File: rtl/sin_series_ctrl_q88_mul.sv
// Combinational signed Q8.8 multiply: full product, floor shift, saturate to 16 bits.
// The b operand is 17 bits wide so an unsigned 16-bit coefficient can be zero-extended.
module q88_mul
  import sin_series_pkg::*;
#(
  parameter int FRAC = 8
) (
  input  logic signed [Q_W-1:0] a,
  input  logic signed [Q_W:0]   b,
  output logic signed [Q_W-1:0] p
);

  logic signed [2*Q_W:0] prod;
  logic signed [2*Q_W:0] shf;

  // Multiply, arithmetic shift (floor toward -inf), then clamp.
  always_comb begin
    prod = a * b;
    shf  = prod >>> FRAC;
    if (shf > 33'sd32767) begin
      p = 16'sh7FFF;
    end else if (shf < -33'sd32768) begin
      p = 16'sh8000;
    end else begin
      p = $signed(shf[Q_W-1:0]);
    end
  end

endmodule

// File: rtl/sin_series_ctrl.sv
// Sequential sin(x) evaluator: x + sum of NTERMS alternating series terms, one shared
// Q8.8 multiplier, coefficients fetched from an external table addressed by sel.
module sin_series_ctrl
  import sin_series_pkg::*;
#(
  parameter int NTERMS = 5,
  parameter int FRAC   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] x,
  input  logic [15:0] div,
  output logic [2:0]  sel,
  output logic        busy,
  output logic        done,
  output logic [15:0] result
);

  localparam logic [2:0] K_LAST = 3'(NTERMS - 1);

  state_e                 state_q, state_d;
  logic [2:0]             k_q, k_d;
  logic [2:0]             sel_q, sel_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic signed [Q_W-1:0]  result_q, result_d;
  logic signed [Q_W-1:0]  x_q, x_d;
  logic signed [Q_W-1:0]  x2_q, x2_d;
  logic signed [Q_W-1:0]  term_q, term_d;
  logic signed [Q_W-1:0]  acc_q, acc_d;

  logic signed [Q_W-1:0]  mul_a;
  logic signed [Q_W:0]    mul_b;
  logic signed [Q_W-1:0]  mul_p;
  logic signed [Q_W:0]    mul_ext;
  logic signed [Q_W:0]    neg_v;
  logic signed [Q_W:0]    acc_sum;

  q88_mul #(.FRAC(FRAC)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  // Route the shared multiplier operands according to the current step.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      ST_SQR: begin
        mul_a = x_q;
        mul_b = {x_q[Q_W-1], x_q};
      end
      ST_MUL: begin
        mul_a = term_q;
        mul_b = {x2_q[Q_W-1], x2_q};
      end
      ST_SCL: begin
        mul_a = term_q;
        mul_b = {1'b0, div};
      end
      default: ;
    endcase
  end

  // Next-state and datapath update for each step of the series evaluation.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    sel_d    = sel_q;
    done_d   = 1'b0;
    result_d = result_q;
    x_d      = x_q;
    x2_d     = x2_q;
    term_d   = term_q;
    acc_d    = acc_q;
    mul_ext  = {mul_p[Q_W-1], mul_p};
    neg_v    = -mul_ext;
    acc_sum  = {acc_q[Q_W-1], acc_q} + {term_q[Q_W-1], term_q};
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d     = $signed(x);
          term_d  = $signed(x);
          acc_d   = $signed(x);
          k_d     = 3'd0;
          state_d = ST_SQR;
        end
      end
      ST_SQR: begin
        x2_d    = mul_p;
        state_d = ST_MUL;
      end
      ST_MUL: begin
        term_d  = mul_p;
        sel_d   = k_q;
        state_d = ST_SCL;
      end
      ST_SCL: begin
        term_d  = sat17(neg_v);
        state_d = ST_ACC;
      end
      ST_ACC: begin
        acc_d = sat17(acc_sum);
        if (k_q == K_LAST) begin
          result_d = sat17(acc_sum);
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end else begin
          k_d     = k_q + 3'd1;
          state_d = ST_MUL;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Register all state and outputs; reset returns everything to zero/IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      x_q      <= '0;
      x2_q     <= '0;
      term_q   <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      x_q      <= x_d;
      x2_q     <= x2_d;
      term_q   <= term_d;
      acc_q    <= acc_d;
    end
  end

  assign sel    = sel_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_sin_series_ctrl.sv
// Self-checking bench for sin_series_ctrl with an external coefficient table.
module tb_sin_series_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] x;
  logic [15:0] div;
  logic [2:0]  sel;
  logic        busy;
  logic        done;
  logic [15:0] result;

  logic [15:0] coef [0:7];
  logic [15:0] exp_res;
  int          ncmp;
  int          nfail;

  sin_series_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x      (x),
    .div    (div),
    .sel    (sel),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  assign div = coef[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Q8.8 product with floor rounding, clamped.
  function automatic int qm(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    p = p >>> 8;
    return clamp16(p);
  endfunction

  // sin(x) ~ x + sum_k term_k, term_k = -(term_{k-1} * x^2) * coef[k].
  function automatic logic [15:0] model(input logic [15:0] xv);
    int xs, x2, term, acc;
    xs   = int'($signed(xv));
    x2   = qm(xs, xs);
    term = xs;
    acc  = xs;
    for (int k = 0; k < 5; k++) begin
      term = qm(term, x2);
      term = clamp16(-longint'(qm(term, int'(coef[k]))));
      acc  = clamp16(longint'(acc) + longint'(term));
    end
    return 16'(acc);
  endfunction

  task automatic load_nominal();
    coef[0] = 16'd43; coef[1] = 16'd13; coef[2] = 16'd6;
    coef[3] = 16'd4;  coef[4] = 16'd2;
    coef[5] = 16'd0;  coef[6] = 16'd0;  coef[7] = 16'd0;
  endtask

  // One evaluation; optionally pokes start at edges 3 and 16 after accept.
  task automatic do_tx(input logic [15:0] xv, input bit poke, input string tag);
    logic [15:0] expv;
    expv  = model(xv);
    start = 1'b1;
    x     = xv;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_acc"}, busy, 1);
    for (int e = 1; e <= 19; e++) begin
      start = poke && (e == 3 || e == 16);
      x     = 16'($urandom);
      @(posedge clk); #1;
      chk({tag, "_done"}, done, (e == 16));
      chk({tag, "_busy"}, busy, (e <= 16));
      if (e >= 2 && e <= 14 && (e % 3) == 2)
        chk({tag, "_sel"}, sel, 32'((e - 2) / 3));
      if (e < 16)
        chk({tag, "_hold"}, result, exp_res);
      else
        chk({tag, "_res"}, result, expv);
    end
    start   = 1'b0;
    exp_res = expv;
  endtask

  initial begin
    ncmp    = 0;
    nfail   = 0;
    exp_res = 16'h0000;
    rst     = 1'b1;
    start   = 1'b1;
    x       = 16'h0100;
    load_nominal();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sel", sel, 0);
    chk("rst_result", result, 0);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", busy, 0);

    do_tx(16'h0100, 1'b0, "one");
    chk("one_const", result, 16'h00D8);
    do_tx(16'hFF00, 1'b0, "mone");
    chk("mone_const", result, 16'hFF2A);
    do_tx(16'h0000, 1'b0, "zero");
    chk("zero_const", result, 16'h0000);
    do_tx(16'h7FFF, 1'b0, "maxpos");
    do_tx(16'h8000, 1'b0, "maxneg");
    do_tx(16'h0192, 1'b1, "poke");
    repeat (3) begin
      @(posedge clk); #1;
      chk("poke_idle_busy", busy, 0);
      chk("poke_idle_res", result, exp_res);
    end

    // Reset in the MUL step of k=2, with a start coincident with reset.
    start = 1'b1;
    x     = 16'h00C0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    chk("midrst_sel", sel, 0);
    rst   = 1'b0;
    start = 1'b0;
    exp_res = 16'h0000;
    @(posedge clk); #1;
    chk("midrst_start_ignored", busy, 0);
    do_tx(16'h00C0, 1'b0, "after_rst");

    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) begin
        load_nominal();
      end else begin
        for (int k = 0; k < 5; k++) coef[k] = 16'($urandom_range(0, (i % 4 == 1) ? 255 : 65535));
      end
      do_tx(16'($urandom), (i % 3) == 0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
